// File: rtl/tod_datapath_if.sv
// -----------------------------------------------------------------------------
// tod_datapath_if
// Groups the controller-side signals of the time-of-day datapath.
//   master : control FSM / bench side, drives run/clr/calibration/load/alarm
//            controls and observes the time fields and pulses
//   slave  : datapath side, receives the controls and drives the time outputs
// Control : clr, run, up, dn, sel[1:0], load, ld_hour[4:0], ld_min[5:0],
//           ld_sec[5:0], alarm_wr, alarm_hour[4:0], alarm_min[5:0], alarm_en
// Status  : csec[6:0], sec[5:0], min[5:0], hour[4:0], hour12[3:0], pm,
//           day_tick, alarm_hit
// -----------------------------------------------------------------------------
interface tod_datapath_if;
   logic       clr;
   logic       run;
   logic       up;
   logic       dn;
   logic [1:0] sel;
   logic       load;
   logic [4:0] ld_hour;
   logic [5:0] ld_min;
   logic [5:0] ld_sec;
   logic       alarm_wr;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       alarm_en;
   logic [6:0] csec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [3:0] hour12;
   logic       pm;
   logic       day_tick;
   logic       alarm_hit;

   modport master (
      output clr, run, up, dn, sel, load, ld_hour, ld_min, ld_sec,
             alarm_wr, alarm_hour, alarm_min, alarm_en,
      input  csec, sec, min, hour, hour12, pm, day_tick, alarm_hit
   );

   modport slave (
      input  clr, run, up, dn, sel, load, ld_hour, ld_min, ld_sec,
             alarm_wr, alarm_hour, alarm_min, alarm_en,
      output csec, sec, min, hour, hour12, pm, day_tick, alarm_hit
   );
endinterface

// File: rtl/tod_datapath.sv
// -----------------------------------------------------------------------------
// tod_datapath
// Time-of-day counter (centisecond/second/minute/hour) advanced by a run-gated
// prescaler, with field calibration, full-time load, one deferred tick,
// alarm compare, day rollover pulse and 12-hour display decode.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : tod_datapath_if.slave (controls in, time fields and pulses out)
// -----------------------------------------------------------------------------
module tod_datapath #(
   parameter int DIV_CSEC  = 1_000_000,
   parameter int INIT_HOUR = 12,
   parameter bit CAL_CARRY = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   tod_datapath_if.slave  bus
);

   localparam int            PW         = $clog2(DIV_CSEC);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_CSEC - 1);
   localparam logic [4:0]    HOUR_RST   = 5'(INIT_HOUR);

   logic [PW-1:0] r_presc;
   logic          r_tick_pend;
   logic [6:0]    r_csec;
   logic [5:0]    r_sec;
   logic [5:0]    r_min;
   logic [4:0]    r_hour;
   logic [4:0]    r_alarm_hour;
   logic [5:0]    r_alarm_min;
   logic          r_day_tick;
   logic          r_alarm_hit;

   logic          w_tick, w_cal, w_adv, w_inc, w_dec, w_prop;
   logic [1:0]    w_start;
   logic          w_step0, w_step1, w_step2, w_step3;
   logic          w_wrap0, w_wrap1, w_wrap2;
   logic [6:0]    w_csec_n;
   logic [5:0]    w_sec_n, w_min_n;
   logic [4:0]    w_hour_n;
   logic [4:0]    w_ld_hour;
   logic [5:0]    w_ld_min, w_ld_sec;
   logic          w_midnight, w_alarm_match;

   // Modulo-lim increment / decrement of a field value (lim <= 100).
   function automatic logic [6:0] f_inc_wrap(input logic [6:0] v, input logic [6:0] lim);
      return (v >= lim - 7'd1) ? 7'd0 : v + 7'd1;
   endfunction

   function automatic logic [6:0] f_dec_wrap(input logic [6:0] v, input logic [6:0] lim);
      return (v == 7'd0) ? lim - 7'd1 : v - 7'd1;
   endfunction

   assign w_tick  = bus.run && (r_presc == PRESC_LAST);
   assign w_cal   = bus.up ^ bus.dn;
   // A tick blocked by calibration is remembered in r_tick_pend and replayed here.
   assign w_adv   = (w_tick || r_tick_pend) && !bus.load && !w_cal;
   assign w_inc   = w_adv || (w_cal && bus.up);
   assign w_dec   = w_cal && bus.dn;
   assign w_prop  = w_adv || CAL_CARRY;
   assign w_start = w_adv ? 2'd0 : bus.sel;

   // Field would wrap in the current direction (carry on inc, borrow on dec).
   assign w_wrap0 = w_inc ? (r_csec == 7'd99) : (r_csec == 7'd0);
   assign w_wrap1 = w_inc ? (r_sec  == 6'd59) : (r_sec  == 6'd0);
   assign w_wrap2 = w_inc ? (r_min  == 6'd59) : (r_min  == 6'd0);

   // Out-of-range load fields fall back to zero individually.
   assign w_ld_hour = (bus.ld_hour > 5'd23) ? 5'd0 : bus.ld_hour;
   assign w_ld_min  = (bus.ld_min  > 6'd59) ? 6'd0 : bus.ld_min;
   assign w_ld_sec  = (bus.ld_sec  > 6'd59) ? 6'd0 : bus.ld_sec;

   assign w_midnight = (r_hour == 5'd23) && (r_min == 6'd59) &&
                       (r_sec == 6'd59) && (r_csec == 7'd99);
   assign w_alarm_match = (w_hour_n == r_alarm_hour) && (w_min_n == r_alarm_min) &&
                          (w_sec_n == 6'd0) && (w_csec_n == 7'd0);

   // Next field values for an advance or a calibration step, with carry chain.
   always_comb begin
      w_step0  = 1'b0;
      w_step1  = 1'b0;
      w_step2  = 1'b0;
      w_step3  = 1'b0;
      w_csec_n = r_csec;
      w_sec_n  = r_sec;
      w_min_n  = r_min;
      w_hour_n = r_hour;
      if (w_inc || w_dec) begin
         w_step0 = (w_start == 2'd0);
         w_step1 = (w_start == 2'd1) || (w_prop && w_step0 && w_wrap0);
         w_step2 = (w_start == 2'd2) || (w_prop && w_step1 && w_wrap1);
         w_step3 = (w_start == 2'd3) || (w_prop && w_step2 && w_wrap2);
         w_csec_n = !w_step0 ? r_csec :
                    (w_inc ? f_inc_wrap(r_csec, 7'd100) : f_dec_wrap(r_csec, 7'd100));
         w_sec_n  = !w_step1 ? r_sec :
                    6'(w_inc ? f_inc_wrap({1'b0, r_sec}, 7'd60) : f_dec_wrap({1'b0, r_sec}, 7'd60));
         w_min_n  = !w_step2 ? r_min :
                    6'(w_inc ? f_inc_wrap({1'b0, r_min}, 7'd60) : f_dec_wrap({1'b0, r_min}, 7'd60));
         w_hour_n = !w_step3 ? r_hour :
                    5'(w_inc ? f_inc_wrap({2'b00, r_hour}, 7'd24) : f_dec_wrap({2'b00, r_hour}, 7'd24));
      end else begin
         w_csec_n = r_csec;
         w_sec_n  = r_sec;
         w_min_n  = r_min;
         w_hour_n = r_hour;
      end
   end

   // Prescaler: counts while run, holds otherwise, restarts on load.
   always_ff @(posedge clk) begin
      if (rst || bus.clr || bus.load) begin
         r_presc <= '0;
      end else if (bus.run) begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end else begin
         r_presc <= r_presc;
      end
   end

   // Single-entry deferred tick; a second blocked tick is dropped.
   always_ff @(posedge clk) begin
      if (rst || bus.clr || bus.load) begin
         r_tick_pend <= 1'b0;
      end else if (w_cal && w_tick) begin
         r_tick_pend <= 1'b1;
      end else if (w_adv) begin
         r_tick_pend <= 1'b0;
      end else begin
         r_tick_pend <= r_tick_pend;
      end
   end

   // Time fields: reset/clear, load, or the combinational next value.
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         r_csec <= 7'd0;
         r_sec  <= 6'd0;
         r_min  <= 6'd0;
         r_hour <= HOUR_RST;
      end else if (bus.load) begin
         r_csec <= 7'd0;
         r_sec  <= w_ld_sec;
         r_min  <= w_ld_min;
         r_hour <= w_ld_hour;
      end else begin
         r_csec <= w_csec_n;
         r_sec  <= w_sec_n;
         r_min  <= w_min_n;
         r_hour <= w_hour_n;
      end
   end

   // Day rollover and alarm pulses, only ever from a real advance.
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         r_day_tick  <= 1'b0;
         r_alarm_hit <= 1'b0;
      end else begin
         r_day_tick  <= w_adv && w_midnight;
         r_alarm_hit <= w_adv && bus.alarm_en && w_alarm_match;
      end
   end

   // Alarm registers survive clr; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm_hour <= 5'd0;
         r_alarm_min  <= 6'd0;
      end else if (bus.alarm_wr) begin
         r_alarm_hour <= bus.alarm_hour;
         r_alarm_min  <= bus.alarm_min;
      end else begin
         r_alarm_hour <= r_alarm_hour;
         r_alarm_min  <= r_alarm_min;
      end
   end

   assign bus.csec      = r_csec;
   assign bus.sec       = r_sec;
   assign bus.min       = r_min;
   assign bus.hour      = r_hour;
   assign bus.day_tick  = r_day_tick;
   assign bus.alarm_hit = r_alarm_hit;
   // 12-hour decode: 0 -> 12, 13..23 -> 1..11.
   assign bus.hour12 = (r_hour == 5'd0)  ? 4'd12 :
                       (r_hour > 5'd12)  ? 4'(r_hour - 5'd12) : r_hour[3:0];
   assign bus.pm     = (r_hour >= 5'd12);

endmodule

// File: tb/tb_tod_datapath.sv
// -----------------------------------------------------------------------------
// tb_tod_datapath
// Drives two datapaths (no-carry and carry calibration) with identical stimulus
// and compares both every cycle against a time-of-day model that keeps the
// time as one centisecond-of-day count.
// -----------------------------------------------------------------------------
module tb_tod_datapath;
   localparam int DIV  = 4;
   localparam int INIT = 12;
   localparam int DAY  = 8640000;

   logic clk = 1'b0;
   logic rst;
   logic clr, run, up, dn, load, alarm_wr, alarm_en;
   logic [1:0] sel;
   logic [4:0] ld_hour, alarm_hour;
   logic [5:0] ld_min, ld_sec, alarm_min;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, index 0 = no-carry DUT, index 1 = carry DUT.
   int m_t[2], m_pre[2];
   bit m_pend[2], m_day[2], m_hit[2];
   int m_ah, m_am;
   int cnt_day, cnt_hit;

   tod_datapath_if bus0 ();
   tod_datapath_if bus1 ();

   assign bus0.clr = clr;           assign bus1.clr = clr;
   assign bus0.run = run;           assign bus1.run = run;
   assign bus0.up = up;             assign bus1.up = up;
   assign bus0.dn = dn;             assign bus1.dn = dn;
   assign bus0.sel = sel;           assign bus1.sel = sel;
   assign bus0.load = load;         assign bus1.load = load;
   assign bus0.ld_hour = ld_hour;   assign bus1.ld_hour = ld_hour;
   assign bus0.ld_min = ld_min;     assign bus1.ld_min = ld_min;
   assign bus0.ld_sec = ld_sec;     assign bus1.ld_sec = ld_sec;
   assign bus0.alarm_wr = alarm_wr; assign bus1.alarm_wr = alarm_wr;
   assign bus0.alarm_hour = alarm_hour; assign bus1.alarm_hour = alarm_hour;
   assign bus0.alarm_min = alarm_min;   assign bus1.alarm_min = alarm_min;
   assign bus0.alarm_en = alarm_en; assign bus1.alarm_en = alarm_en;

   tod_datapath #(.DIV_CSEC(DIV), .INIT_HOUR(INIT), .CAL_CARRY(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0));
   tod_datapath #(.DIV_CSEC(DIV), .INIT_HOUR(INIT), .CAL_CARRY(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int hms(input int h, input int m, input int s, input int c);
      return ((h * 60 + m) * 60 + s) * 100 + c;
   endfunction

   function automatic logic [23:0] pack_t(input int t);
      return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
   endfunction

   // Calibration of one field; with carry it is plain +/- one unit modulo a day.
   function automatic int cal(input int t, input int s, input bit inc, input bit carry);
      int f[4], lim[4], unit[4];
      lim  = '{100, 60, 60, 24};
      unit = '{1, 100, 6000, 360000};
      if (carry) return inc ? (t + unit[s]) % DAY : (t + DAY - unit[s]) % DAY;
      f[0] = t % 100; f[1] = (t / 100) % 60; f[2] = (t / 6000) % 60; f[3] = t / 360000;
      f[s] = inc ? (f[s] + 1) % lim[s] : (f[s] + lim[s] - 1) % lim[s];
      return hms(f[3], f[2], f[1], f[0]);
   endfunction

   // Model state after the coming clock edge, from the current inputs.
   task automatic model_next();
      for (int k = 0; k < 2; k++) begin
         bit tick;
         tick = run && (m_pre[k] == DIV - 1);
         m_day[k] = 1'b0;
         m_hit[k] = 1'b0;
         if (rst || clr) begin
            m_t[k] = INIT * 360000; m_pre[k] = 0; m_pend[k] = 1'b0;
         end else begin
            m_pre[k] = load ? 0 : (run ? (tick ? 0 : m_pre[k] + 1) : m_pre[k]);
            if (load) begin
               m_t[k] = hms(ld_hour > 23 ? 0 : int'(ld_hour), ld_min > 59 ? 0 : int'(ld_min),
                            ld_sec > 59 ? 0 : int'(ld_sec), 0);
               m_pend[k] = 1'b0;
            end else if (up != dn) begin
               m_t[k] = cal(m_t[k], int'(sel), up, k == 1);
               if (tick) m_pend[k] = 1'b1;
            end else if (tick || m_pend[k]) begin
               m_t[k] = (m_t[k] + 1) % DAY;
               m_pend[k] = 1'b0;
               m_day[k] = (m_t[k] == 0);
               m_hit[k] = alarm_en && (m_ah < 24) && (m_am < 60) && (m_t[k] == hms(m_ah, m_am, 0, 0));
            end
         end
      end
      if (rst) begin
         m_ah = 0; m_am = 0;
      end else if (alarm_wr) begin
         m_ah = int'(alarm_hour); m_am = int'(alarm_min);
      end
   endtask

   task automatic check_dut(input int k, input logic [23:0] t, input logic [3:0] h12,
                            input logic pm, input logic dt, input logic ah);
      int h;
      h = m_t[k] / 360000;
      check_eq($sformatf("d%0d_time", k), 32'(t), 32'(pack_t(m_t[k])));
      check_eq($sformatf("d%0d_hour12", k), 32'(h12), (h % 12 == 0) ? 32'd12 : 32'(h % 12));
      check_eq($sformatf("d%0d_pm", k), 32'(pm), 32'(h >= 12));
      check_eq($sformatf("d%0d_day_tick", k), 32'(dt), 32'(m_day[k]));
      check_eq($sformatf("d%0d_alarm_hit", k), 32'(ah), 32'(m_hit[k]));
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      check_dut(0, {bus0.hour, bus0.min, bus0.sec, bus0.csec}, bus0.hour12, bus0.pm,
                bus0.day_tick, bus0.alarm_hit);
      check_dut(1, {bus1.hour, bus1.min, bus1.sec, bus1.csec}, bus1.hour12, bus1.pm,
                bus1.day_tick, bus1.alarm_hit);
      cnt_day += int'(bus0.day_tick);
      cnt_hit += int'(bus0.alarm_hit);
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load = 1'b1; ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
      step();
      load = 1'b0;
   endtask

   task automatic alarm_run(input bit en, input int exp_hits);
      alarm_en = en;
      run = 1'b0;
      do_load(7, 29, 59);
      run = 1'b1;
      cnt_hit = 0;
      repeat (410) step();
      check_eq(en ? "alarm_hit_once" : "alarm_off_none", 32'(cnt_hit), 32'(exp_hits));
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; run = 1'b0; up = 1'b0; dn = 1'b0; sel = 2'd0; load = 1'b0;
      ld_hour = 5'd0; ld_min = 6'd0; ld_sec = 6'd0;
      alarm_wr = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0; alarm_en = 1'b0;
      cnt_day = 0; cnt_hit = 0;
      m_t = '{0, 0}; m_pre = '{0, 0}; m_ah = 0; m_am = 0;
      step(); step();
      rst = 1'b0;
      check_eq("rst_time", 32'({bus0.hour, bus0.min, bus0.sec, bus0.csec}), 32'(pack_t(hms(12, 0, 0, 0))));

      // Basic counting from reset
      run = 1'b1;
      repeat (4) step();
      check_eq("first_csec", 32'(bus0.csec), 32'd1);
      repeat (396) step();
      check_eq("one_sec", 32'({bus0.sec, bus0.csec}), 32'({6'd1, 7'd0}));
      check_eq("hour12_noon", 32'({bus0.hour12, bus0.pm}), 32'({4'd12, 1'b1}));

      // Day rollover
      do_load(23, 59, 59);
      cnt_day = 0;
      repeat (400) step();
      check_eq("midnight", 32'({bus0.hour, bus0.min, bus0.sec, bus0.csec}), 32'd0);
      check_eq("midnight_12h", 32'({bus0.hour12, bus0.pm}), 32'({4'd12, 1'b0}));
      repeat (3) step();
      check_eq("day_tick_cnt", 32'(cnt_day), 32'd1);

      // Calibration wrap with and without carry
      run = 1'b0;
      do_load(0, 0, 59);
      sel = 2'd1; up = 1'b1; step(); up = 1'b0;
      check_eq("cal_nocarry", 32'({bus0.min, bus0.sec}), 32'd0);
      check_eq("cal_carry", 32'({bus1.min, bus1.sec}), 32'({6'd1, 6'd0}));
      do_load(0, 0, 0);
      sel = 2'd0; dn = 1'b1; step(); dn = 1'b0;
      check_eq("borrow_carry", 32'({bus1.hour, bus1.min, bus1.sec, bus1.csec}),
               32'(pack_t(hms(23, 59, 59, 99))));
      check_eq("borrow_nocarry", 32'(bus0.csec), 32'd99);

      // Deferred tick: calibration coincides with a prescaler tick
      do_load(0, 0, 0);
      up = 1'b1; repeat (10) step(); up = 1'b0;
      run = 1'b1; repeat (3) step();
      up = 1'b1; step(); up = 1'b0; run = 1'b0;
      check_eq("defer_cal", 32'(bus0.csec), 32'd11);
      step();
      check_eq("defer_apply", 32'(bus0.csec), 32'd12);
      up = 1'b1; dn = 1'b1; step(); up = 1'b0; dn = 1'b0;
      check_eq("up_dn_ignored", 32'(bus0.csec), 32'd12);

      // Alarm
      alarm_wr = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30; step(); alarm_wr = 1'b0;
      alarm_run(1'b1, 1);
      alarm_run(1'b0, 0);
      alarm_en = 1'b1; run = 1'b0;
      do_load(7, 29, 0);
      cnt_hit = 0;
      sel = 2'd2; up = 1'b1; step(); up = 1'b0;
      repeat (3) step();
      check_eq("alarm_cal_none", 32'(cnt_hit), 32'd0);

      // Out-of-range load
      do_load(5, 61, 10);
      check_eq("load_clamp", 32'({bus0.hour, bus0.min, bus0.sec, bus0.csec}),
               32'(pack_t(hms(5, 0, 10, 0))));

      // Reset with a pending tick
      run = 1'b1; do_load(1, 2, 3);
      repeat (3) step();
      sel = 2'd0; up = 1'b1; step(); up = 1'b0; run = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      repeat (3) step();
      check_eq("rst_pend", 32'({bus0.hour, bus0.min, bus0.sec, bus0.csec}),
               32'(pack_t(hms(12, 0, 0, 0))));

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 499) == 0);
         clr      = ($urandom_range(0, 199) == 0);
         load     = ($urandom_range(0, 99) == 0);
         ld_hour  = 5'($urandom_range(0, 31));
         ld_min   = 6'($urandom_range(0, 63));
         ld_sec   = 6'($urandom_range(0, 63));
         run      = ($urandom_range(0, 9) != 0);
         up       = ($urandom_range(0, 7) == 0);
         dn       = ($urandom_range(0, 7) == 0);
         sel      = 2'($urandom_range(0, 3));
         alarm_wr = ($urandom_range(0, 99) == 0);
         alarm_hour = 5'($urandom_range(0, 24));
         alarm_min  = 6'($urandom_range(0, 60));
         alarm_en = ($urandom_range(0, 1) == 1);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tod_datapath.md
Name: tod_datapath

Overview:
Parametrised time-of-day datapath, next generation of the watch datapath. Keeps a centisecond/second/minute/hour count from a run-gated prescaler. Adds over the previous generation:
- field-select calibration with optional carry/borrow propagation
- synchronous full-time load
- deferred-tick handling
- alarm compare, day rollover pulse and 12-hour display outputs

Sits between the UART/button control FSM and the FND display mux.

Parameters:
DIV_CSEC, 1_000_000, clk cycles per centisecond tick (>=2)
INIT_HOUR, 12, hour value after rst/clr (0..23)
CAL_CARRY, 0, 1: calibration wrap propagates carry/borrow to higher fields; 0: field wraps alone

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear to initial time, prescaler to 0
run  in  1  1: prescaler counts; 0: time frozen (calibration/load still work)
up  in  1  increment selected field (1-cycle pulse, debounced upstream)
dn  in  1  decrement selected field
sel  in  2  calibration field: 0 csec, 1 sec, 2 min, 3 hour
load  in  1  load ld_hour/ld_min/ld_sec, csec<=0
ld_hour  in  5  load value
ld_min  in  6  load value
ld_sec  in  6  load value
alarm_wr  in  1  latch alarm_hour/alarm_min into alarm registers
alarm_hour  in  5  alarm hour
alarm_min  in  6  alarm minute
alarm_en  in  1  enables alarm_hit
csec  out  7  0..99
sec  out  6  0..59
min  out  6  0..59
hour  out  5  0..23
hour12  out  4  1..12, combinational from hour (0->12, 13..23->1..11)
pm  out  1  hour>=12, combinational
day_tick  out  1  1-cycle pulse on 23:59:59.99 -> 00:00:00.00 advance
alarm_hit  out  1  1-cycle registered pulse on alarm match

Behaviour:
- Reset (rst=1): csec=sec=min=0, hour=INIT_HOUR, prescaler=0, tick_pend=0, alarm regs=0, day_tick=alarm_hit=0. clr does the same except alarm regs are kept.
- Per-cycle priority: rst > clr > load > calibration > advance.
- Prescaler:
  - increments when run=1, holds (not cleared) when run=0.
  - At DIV_CSEC-1 with run=1 it wraps to 0 and raises tick for that cycle.
- Advance: applied when tick or tick_pend is set and no load/cal is effective that cycle. Fields update at that clock edge.
  - Increment chain: csec+1; 99->0 carries into sec; 59->0 carries into min; 59->0 carries into hour; 23->0 with no further carry.
  - First field change is visible DIV_CSEC cycles after run rises from prescaler=0.
- Calibration is effective when exactly one of up/dn=1. up&dn together: ignored, no effect.
  - up: selected field +1, max-1 -> 0.
  - dn: selected field -1, 0 -> max-1.
  - With CAL_CARRY=1 the wrap carries/borrows through the higher fields (same chain as advance). Hour wraps without propagation.
  - Never raises day_tick or alarm_hit.
- Deferred tick:
  - If tick coincides with an effective calibration, tick_pend<=1. The pending advance applies on the first later cycle with no effective load/cal.
  - Only one pending tick is stored. A tick arriving while tick_pend=1 and blocked is lost.
  - tick_pend is cleared when the pending advance applies, and by rst/clr/load.
- Load:
  - hour/min/sec take the ld_* values, csec<=0, prescaler<=0, tick_pend<=0. A coincident tick is discarded.
  - Out-of-range field values (ld_hour>23, ld_min>59, ld_sec>59) load 0 for that field only.
- Alarm:
  - alarm_wr stores alarm_hour/alarm_min. Out-of-range values are stored as-is and never match.
  - alarm_hit=1 in the cycle after an advance that produces min=alarm_min, hour=alarm_hour, sec=0, csec=0, with alarm_en=1.
  - Load/cal reaching the alarm time gives no hit.
- day_tick is registered and asserted the cycle after the wrapping advance, for 1 cycle.
- Only the outputs csec/sec/min/hour and the two pulses are registered. hour12 and pm are decoded from hour.

Test Plan:
- DIV_CSEC=4, rst, run=1 held -> csec 0->1 after 4 cycles; after 400 cycles sec=1, csec=0; hour=12, hour12=12, pm=1.
- load 23:59:59 then run -> after 100 ticks all fields 0, day_tick high exactly 1 cycle, hour12=12, pm=0.
- CAL_CARRY=0: sec=59, sel=1, up -> sec=0, min unchanged. CAL_CARRY=1: same stimulus -> sec=0, min+1. dn at 00:00:00.00 sel=0 -> 23:59:59.99.
- up pulse in the same cycle as tick, csec=10, sel=0 -> csec=11 next cycle, then 12 one cycle later (deferred tick). up&dn together -> no change.
- alarm_wr 07:30, alarm_en=1, load 07:29:59 -> alarm_hit pulses once, one cycle after the advance to 07:30:00.00. Repeat with alarm_en=0 -> no pulse. Repeat via up on min -> no pulse.
- load ld_min=61, ld_hour=5, ld_sec=10 -> 05:00:10.00. rst asserted mid-run with tick_pend=1 -> 12:00:00.00, no late advance.
